// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between the display scan controller and its digit source / decoder side.
// The slave is the scan controller; the master drives the digit data and observes the scan outputs.
interface display_scan_ctrl_if;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        en;
  logic [1:0]  a;
  logic [3:0]  digit;
  logic        dp;
  logic        frame_start;

  modport master (
    output hex_in, dp_in, blank_in,
    input  en, a, digit, dp, frame_start
  );

  modport slave (
    input  hex_in, dp_in, blank_in,
    output en, a, digit, dp, frame_start
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner: drives a 2-to-4 decoder with per-digit on time,
// inter-digit dead time, blanking and a per-frame input snapshot.
module display_scan_ctrl #(
  parameter int unsigned ON_CYCLES   = 50000,
  parameter int unsigned DEAD_CYCLES = 500,
  parameter int unsigned CNT_W       = 16
) (
  input logic                clk,
  input logic                rst_n,
  display_scan_ctrl_if.slave dsp
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ON   = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = HAS_DEAD ? CNT_W'(DEAD_CYCLES - 1) : '0;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      hex_snap;
  logic [3:0]       dp_snap;
  logic [3:0]       blank_snap;
  logic             frame_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      idx         <= '0;
      cnt         <= '0;
      hex_snap    <= '0;
      dp_snap     <= '0;
      blank_snap  <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_LOAD: begin
          hex_snap    <= dsp.hex_in;
          dp_snap     <= dsp.dp_in;
          blank_snap  <= dsp.blank_in;
          idx         <= '0;
          cnt         <= '0;
          state       <= ST_ON;
          frame_start <= 1'b1;
        end
        ST_ON: begin
          if (cnt == ON_LAST) begin
            cnt <= '0;
            // Without dead time the next digit follows directly from ON.
            if (HAS_DEAD)
              state <= ST_DEAD;
            else if (idx == 2'd3)
              state <= ST_LOAD;
            else
              idx <= idx + 2'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          if (cnt == DEAD_LAST) begin
            cnt <= '0;
            if (idx == 2'd3) begin
              state <= ST_LOAD;
            end else begin
              idx   <= idx + 2'd1;
              state <= ST_ON;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Outputs decode registered state only; inputs reach them solely through the snapshots.
  assign dsp.en          = (state == ST_ON) & ~blank_snap[idx];
  assign dsp.a           = idx;
  assign dsp.digit       = hex_snap[{idx, 2'b00} +: 4];
  assign dsp.dp          = (state == ST_ON) & dp_snap[idx];
  assign dsp.frame_start = frame_start;

endmodule
